regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single regfile write port (we / rd_addr / rd_data) between two writeback requesters: req0 (ALU/EX writeback) and req1 (load/MEM writeback).
- Each requester uses a valid/ready handshake. At most one write is granted per cycle.
- Granted writes are registered before they drive the regfile. Writes to x0 are filtered out.
- Fixed priority goes to req0. A starvation counter guarantees forward progress for req1.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- STARVE_LIMIT, 4, number of consecutive denied req1 cycles before req1 is forced to win; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset
- req0_valid  in  1  req0 has a write pending
- req0_ready  out  1  req0 write accepted this cycle when valid
- req0_addr  in  ADDR_W  req0 destination register
- req0_data  in  DATA_W  req0 write data
- req1_valid  in  1  req1 has a write pending
- req1_ready  out  1  req1 write accepted this cycle when valid
- req1_addr  in  ADDR_W  req1 destination register
- req1_data  in  DATA_W  req1 write data
- we  out  1  regfile write enable, registered
- rd_addr  out  ADDR_W  regfile write address, registered
- rd_data  out  DATA_W  regfile write data, registered
- starve_boost  out  1  req1 is being force-granted this cycle (status/debug)

Interface note: one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Reset: asserting rst clears we, rd_addr, rd_data, the starvation counter and starve_boost to 0 immediately. A registered write in flight is discarded. After deassertion, the first grant can occur in the next cycle.
- Handshake: a transfer happens when valid && ready at a rising edge. The ready outputs are combinational from the valids and arbiter state; no ready depends on its own valid.
  - Once valid is raised, a requester must hold valid, addr and data stable until accepted.
- Arbitration (normal mode):
  - req0_ready = !starve_boost
  - req1_ready = starve_boost || !req0_valid
- Starvation counter (sc, 4 bits):
  - Increments each cycle with req1_valid && !req1_ready, saturating at STARVE_LIMIT.
  - Clears on a req1 transfer, or on any cycle with req1_valid low.
  - starve_boost = (sc == STARVE_LIMIT). It stays high until the req1 transfer, which is the next edge.
- Latency: a transfer at edge N produces we=1 with the accepted addr/data during cycle N..N+1. The regfile commits at edge N+1. Peak throughput is 1 write/cycle with no bubbles.
- x0 filter: a transfer with addr==0 is still accepted (ready/valid completes), but the registered slot has we=0. rd_addr and rd_data still update.
- No transfer at an edge: we=0 next cycle; rd_addr and rd_data hold their previous values.
- Simultaneous requests to the same address:
  - The write granted first commits first; the loser commits later and is the final value.
  - Requesters own any ordering requirement between them.
- The arbiter never drops or duplicates a non-x0 transfer.

Optional Feature:
- Macro REGFILE_WR_ARB_RR_EN.
- Defined: round-robin arbitration using a 1-bit last-winner pointer, reset to "req1 last" so that req0 wins the first conflict.
  - On conflict, the requester that did not win last gets ready; with a single requester, that requester gets ready.
  - The starvation counter is removed and starve_boost is tied to 0.
- Undefined: fixed priority plus starvation counter, as described in Behaviour.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5 and REG_DATA_W=32
  - REG_ZERO=5'd0
  - a wb_req struct typedef {addr, data}
- Natural single sub-module: wr_arb_sel, the combinational grant logic plus starvation counter or RR pointer. The top keeps the output register and the x0 filter.

Test Plan:
- Reset mid-write: accept req0 (addr 3, data 32'hA5A5A5A5), assert rst before the next edge -> we=0, rd_addr=0, rd_data=0, sc=0 immediately; after release, a new req0 (addr 3, data 32'h1) gives we=1 one cycle later.
- Single requester: req0 (addr 1, data 32'h12345678) -> req0_ready=1; next cycle we=1, rd_addr=1, rd_data=32'h12345678. Then req1 alone (addr 2, data 32'h87654321) gives the same 1-cycle latency.
- x0 filter: req1 (addr 0, data 32'hFFFFFFFF) -> req1_ready=1; next cycle we=0. A follow-up regfile read of x0 returns 0.
- Conflict, fixed priority: both valid every cycle, req0 addr 5 with distinct data each cycle, req1 addr 6 data 32'hDEADBEEF, STARVE_LIMIT=4.
  - req0 wins 4 cycles; 5th cycle has starve_boost=1, req1_ready=1, req0_ready=0.
  - Next cycle: we=1, rd_addr=6; sc returns to 0.
- Back-to-back stream: req0 supplies 8 consecutive writes to addrs 1..8 -> we=1 for 8 consecutive cycles, addresses in order, no bubbles.
- With REGFILE_WR_ARB_RR_EN and both valid continuously -> grants alternate req0, req1, req0, ...; starve_boost stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared regfile write-port types and constants. The REGFILE_WR_ARB_RR_EN macro is read by
// the arbiter files that import this package.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Width of the req1 starvation counter; STARVE_LIMIT must fit (1..15).
   localparam int SC_W = 4;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_REQ0 = 2'd1,
      GNT_REQ1 = 2'd2
   } grant_e;

endpackage

// File: rtl/regfile_wr_arbiter_sel.sv
// Grant selection for the regfile write arbiter: fixed priority to req0 with a req1 starvation
// counter, or a 1-bit round-robin pointer when REGFILE_WR_ARB_RR_EN is defined.
module wr_arb_sel
   import regfile_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   req0_valid,
   input  logic   req1_valid,
   output logic   req0_ready,
   output logic   req1_ready,
   output logic   starve_boost,
   output grant_e grant
);

`ifdef REGFILE_WR_ARB_RR_EN

   // last_q = 1 means req1 won the most recent transfer; reset there so req0 wins first.
   logic last_q;
   logic last_d;

   always_comb begin
      starve_boost = 1'b0;
      req0_ready   = !(req1_valid && !last_q);
      req1_ready   = !(req0_valid && last_q);
      last_d       = last_q;
      if (req0_valid && req0_ready) begin
         last_d = 1'b0;
      end else if (req1_valid && req1_ready) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

`else

   localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

   logic [SC_W-1:0] sc_q;
   logic [SC_W-1:0] sc_d;

   // NOTE: every output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      starve_boost = (sc_q == LIMIT);
      req0_ready   = !starve_boost;
      req1_ready   = starve_boost || !req0_valid;
      sc_d         = sc_q;
      if (!req1_valid || req1_ready) begin
         sc_d = '0;
      end else if (sc_q != LIMIT) begin
         sc_d = sc_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sc_q <= '0;
      end else begin
         sc_q <= sc_d;
      end
   end

`endif

   // The ready equations never let both requesters transfer in the same cycle.
   always_comb begin
      grant = GNT_NONE;
      if (req0_valid && req0_ready) begin
         grant = GNT_REQ0;
      end else if (req1_valid && req1_ready) begin
         grant = GNT_REQ1;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester regfile write-port arbiter with registered write slot and x0 filter.
// Define REGFILE_WR_ARB_RR_EN for round-robin arbitration instead of fixed priority + starvation.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDR_W       = REG_ADDR_W,
   parameter int DATA_W       = REG_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              we,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              starve_boost
);

   grant_e grant;

   wr_arb_sel #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_sel (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req1_valid  (req1_valid),
      .req0_ready  (req0_ready),
      .req1_ready  (req1_ready),
      .starve_boost(starve_boost),
      .grant       (grant)
   );

   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              we_q;
   logic              we_d;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] rd_addr_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   // An x0 transfer still completes the handshake and loads addr/data, but never raises we.
   always_comb begin
      sel_addr  = req0_addr;
      sel_data  = req0_data;
      if (grant == GNT_REQ1) begin
         sel_addr = req1_addr;
         sel_data = req1_data;
      end
      we_d      = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      if (grant != GNT_NONE) begin
         we_d      = (sel_addr != ADDR_W'(REG_ZERO));
         rd_addr_d = sel_addr;
         rd_data_d = sel_data;
      end
   end

   // NOTE: the data slot is reset on purpose: it is a single output register, not a storage
   // array, and an in-flight write must be discarded with the outputs reading back as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q      <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         we_q      <= we_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign we      = we_q;
   assign rd_addr = rd_addr_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized self-checking bench for regfile_wr_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   localparam int ADDR_W       = 5;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              we;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              starve_boost;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
      .starve_boost(starve_boost)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Regfile as seen by the DUT's write port, and the regfile the model says should result.
   logic [DATA_W-1:0] dut_rf   [32] = '{default: '0};
   logic [DATA_W-1:0] model_rf [32] = '{default: '0};

   always @(posedge clk) begin
      if (we) dut_rf[rd_addr] <= rd_data;
   end

   // Requester intentions (held until the model says the transfer happened).
   logic    v0 = 1'b0;
   logic    v1 = 1'b0;
   wb_req_t r0 = '0;
   wb_req_t r1 = '0;

   // Model state: how long req1 has been waiting, who won last, and the expected write slot.
   int                waited      = 0;
   int                last_winner = 1;
   logic              exp_we      = 1'b0;
   logic [ADDR_W-1:0] exp_addr    = '0;
   logic [DATA_W-1:0] exp_data    = '0;
   int                win_log[$];

   task automatic model_reset();
      waited      = 0;
      last_winner = 1;
      exp_we      = 1'b0;
      exp_addr    = '0;
      exp_data    = '0;
   endtask

   // Who should win this cycle, from the arbitration rules.
   task automatic model_decide(output logic w0, output logic w1, output logic boost);
`ifdef REGFILE_WR_ARB_RR_EN
      boost = 1'b0;
      if (v0 && v1) begin
         w0 = (last_winner == 1);
         w1 = !w0;
      end else begin
         w0 = v0;
         w1 = v1;
      end
`else
      boost = (waited == STARVE_LIMIT);
      w1    = v1 && (boost || !v0);
      w0    = v0 && !boost;
`endif
   endtask

   task automatic cycle(input string tag);
      logic w0, w1, boost;
      wb_req_t won;
      @(negedge clk);
      req0_valid = v0; req0_addr = r0.addr; req0_data = r0.data;
      req1_valid = v1; req1_addr = r1.addr; req1_data = r1.data;
      #1;
      model_decide(w0, w1, boost);
      check({tag, "/xfer0"}, req0_valid && req0_ready, w0);
      check({tag, "/xfer1"}, req1_valid && req1_ready, w1);
      check({tag, "/boost"}, starve_boost, boost);
`ifndef REGFILE_WR_ARB_RR_EN
      check({tag, "/ready0"}, req0_ready, !boost);
      check({tag, "/ready1"}, req1_ready, boost || !v0);
`endif
      @(posedge clk);
      #1;
      if (exp_we) model_rf[exp_addr] = exp_data;
      exp_we = 1'b0;
      if (w0 || w1) begin
         won      = w0 ? r0 : r1;
         exp_addr = won.addr;
         exp_data = won.data;
         exp_we   = (won.addr != REG_ZERO);
         win_log.push_back(w0 ? 0 : 1);
      end
      if (v1 && !w1) waited = (waited < STARVE_LIMIT) ? waited + 1 : STARVE_LIMIT;
      else           waited = 0;
      if (w0) last_winner = 0;
      else if (w1) last_winner = 1;
      if (w0) v0 = 1'b0;
      if (w1) v1 = 1'b0;
      check({tag, "/we"}, we, exp_we);
      check({tag, "/rd_addr"}, rd_addr, exp_addr);
      check({tag, "/rd_data"}, rd_data, exp_data);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int we_cnt;
      int exp_w;
      rst = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      repeat (2) @(negedge clk);
      check("reset/we", we, 1'b0);
      check("reset/rd_addr", rd_addr, '0);
      check("reset/rd_data", rd_data, '0);
      check("reset/boost", starve_boost, 1'b0);
      rst = 1'b0;
      model_reset();

      // Conflict: both valid every cycle, req0 data changes only after acceptance.
      win_log.delete();
      for (int i = 0; i < 10; i++) begin
         if (!v0) begin v0 = 1'b1; r0.addr = 5'd5; r0.data = 32'h5000_0000 + i; end
         if (!v1) begin v1 = 1'b1; r1.addr = 5'd6; r1.data = 32'hDEAD_BEEF; end
         cycle("conflict");
      end
      check("conflict/wins", win_log.size(), 10);
      for (int i = 0; i < win_log.size(); i++) begin
`ifdef REGFILE_WR_ARB_RR_EN
         exp_w = i % 2;
`else
         exp_w = ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 1 : 0;
`endif
         check("conflict/order", win_log[i], exp_w);
      end
      while (v0 || v1) cycle("conflict_drain");

      // Single requesters.
      v0 = 1'b1; r0 = '{addr: 5'd1, data: 32'h1234_5678};
      cycle("single0");
      v1 = 1'b1; r1 = '{addr: 5'd2, data: 32'h8765_4321};
      cycle("single1");
      cycle("idle");

      // x0 filter.
      v1 = 1'b1; r1 = '{addr: 5'd0, data: 32'hFFFF_FFFF};
      cycle("x0");
      cycle("x0_after");

      // Back-to-back stream of 8 writes.
      we_cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         v0 = 1'b1; r0.addr = ADDR_W'(i); r0.data = 32'hC000_0000 + i;
         cycle("stream");
         if (we) we_cnt++;
      end
      check("stream/we_run", we_cnt, 8);
      cycle("stream_end");

      // Reset with a write in flight and req1 partly starved.
      v0 = 1'b1; r0 = '{addr: 5'd3, data: 32'hA5A5_A5A5};
      v1 = 1'b1; r1 = '{addr: 5'd9, data: 32'h0000_0099};
      cycle("rst_pre");
      #2 rst = 1'b1;
      #1;
      check("rst_mid/we", we, 1'b0);
      check("rst_mid/rd_addr", rd_addr, '0);
      check("rst_mid/rd_data", rd_data, '0);
      check("rst_mid/boost", starve_boost, 1'b0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      v0 = 1'b1; r0 = '{addr: 5'd3, data: 32'h0000_0001};
      cycle("rst_post");
      for (int i = 0; i < 2 * (STARVE_LIMIT + 1); i++) begin
         if (!v0) begin v0 = 1'b1; r0.addr = 5'd7; r0.data = 32'h7000_0000 + i; end
         if (!v1) begin v1 = 1'b1; r1.addr = 5'd8; r1.data = 32'h8000_0000 + i; end
         cycle("rst_conflict");
      end

      // Randomized traffic; requesters hold their request until accepted.
      for (int i = 0; i < 400; i++) begin
         if (!v0 && $urandom_range(99) < 60) begin
            v0 = 1'b1; r0.addr = ADDR_W'($urandom_range(31)); r0.data = $urandom;
         end
         if (!v1 && $urandom_range(99) < 70) begin
            v1 = 1'b1; r1.addr = ADDR_W'($urandom_range(31)); r1.data = $urandom;
         end
         cycle("random");
      end
      while (v0 || v1) cycle("drain");
      cycle("flush");
      cycle("flush");

      for (int a = 0; a < 32; a++) begin
         check($sformatf("regfile[%0d]", a), dut_rf[a], model_rf[a]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
